// File: rtl/panel_dump_reader.sv
// Reads a range of PDP-8 memory through the front panel: one Load PC, then
// one Examine per word, presenting each word on a valid/ready stream.
module panel_dump_reader #(
  parameter int SETUP_CYCLES  = 10,
  parameter int PULSE_CYCLES  = 10,
  parameter int SETTLE_CYCLES = 10
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        start,
  input  logic [11:0] start_addr,
  input  logic [12:0] count,
  output logic [11:0] sw,
  output logic        load_pc_btn,
  output logic        examine_btn,
  input  logic [11:0] led,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_address,
  output logic [11:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  localparam int MAX_SP = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int MAX_C  = (MAX_SP > SETTLE_CYCLES) ? MAX_SP : SETTLE_CYCLES;
  localparam int CW     = $clog2(MAX_C + 1);

  // Counters load N-1 and the state exits on the cycle the counter reads zero.
  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] PULSE_LD  = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LPC_SETUP = 3'd1,
    S_LPC_PULSE = 3'd2,
    S_LPC_HOLD  = 3'd3,
    S_EX_PULSE  = 3'd4,
    S_EX_SETTLE = 3'd5,
    S_OUTPUT    = 3'd6,
    S_FINISH    = 3'd7
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [11:0]   addr_q;
  logic [12:0]   remain_q;
  logic [11:0]   sw_q;
  logic          load_pc_q;
  logic          examine_q;
  logic          out_valid_q;
  logic [11:0]   out_address_q;
  logic [11:0]   out_data_q;
  logic          out_last_q;
  logic          busy_q;
  logic          done_q;

  logic [11:0]   addr_d;
  logic [12:0]   remain_d;
  logic          cnt_zero_s;

  // Post-handshake address and remaining-word count; the address wraps at 4096.
  always_comb begin
    addr_d     = addr_q + 12'd1;
    remain_d   = remain_q - 13'd1;
    cnt_zero_s = (cnt_q == {CW{1'b0}});
  end

  // Dump sequencer; every output is a register updated together with the state.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q       <= S_IDLE;
      cnt_q         <= {CW{1'b0}};
      addr_q        <= 12'd0;
      remain_q      <= 13'd0;
      sw_q          <= 12'd0;
      load_pc_q     <= 1'b0;
      examine_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      out_address_q <= 12'd0;
      out_data_q    <= 12'd0;
      out_last_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start && (count != 13'd0)) begin
            addr_q   <= start_addr;
            remain_q <= count;
            sw_q     <= start_addr;
            cnt_q    <= SETUP_LD;
            busy_q   <= 1'b1;
            state_q  <= S_LPC_SETUP;
          end else if (start) begin
            busy_q  <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_FINISH;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end

        S_LPC_SETUP: begin
          if (cnt_zero_s) begin
            load_pc_q <= 1'b1;
            cnt_q     <= PULSE_LD;
            state_q   <= S_LPC_PULSE;
          end else begin
            cnt_q <= cnt_q - {{(CW-1){1'b0}}, 1'b1};
          end
        end

        S_LPC_PULSE: begin
          if (cnt_zero_s) begin
            load_pc_q <= 1'b0;
            cnt_q     <= SETUP_LD;
            state_q   <= S_LPC_HOLD;
          end else begin
            cnt_q <= cnt_q - {{(CW-1){1'b0}}, 1'b1};
          end
        end

        S_LPC_HOLD: begin
          if (cnt_zero_s) begin
            examine_q <= 1'b1;
            cnt_q     <= PULSE_LD;
            state_q   <= S_EX_PULSE;
          end else begin
            cnt_q <= cnt_q - {{(CW-1){1'b0}}, 1'b1};
          end
        end

        S_EX_PULSE: begin
          if (cnt_zero_s) begin
            examine_q <= 1'b0;
            cnt_q     <= SETTLE_LD;
            state_q   <= S_EX_SETTLE;
          end else begin
            cnt_q <= cnt_q - {{(CW-1){1'b0}}, 1'b1};
          end
        end

        S_EX_SETTLE: begin
          if (cnt_zero_s) begin
            out_data_q    <= led;
            out_address_q <= addr_q;
            out_last_q    <= (remain_q == 13'd1);
            out_valid_q   <= 1'b1;
            state_q       <= S_OUTPUT;
          end else begin
            cnt_q <= cnt_q - {{(CW-1){1'b0}}, 1'b1};
          end
        end

        S_OUTPUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            addr_q      <= addr_d;
            remain_q    <= remain_d;
            // The panel auto-increments PC on Examine, so later words need no Load PC.
            if (remain_q == 13'd1) begin
              done_q  <= 1'b1;
              state_q <= S_FINISH;
            end else begin
              examine_q <= 1'b1;
              cnt_q     <= PULSE_LD;
              state_q   <= S_EX_PULSE;
            end
          end else begin
            state_q <= S_OUTPUT;
          end
        end

        S_FINISH: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          load_pc_q   <= 1'b0;
          examine_q   <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign sw          = sw_q;
  assign load_pc_btn = load_pc_q;
  assign examine_btn = examine_q;
  assign out_valid   = out_valid_q;
  assign out_address = out_address_q;
  assign out_data    = out_data_q;
  assign out_last    = out_last_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: doc/panel_dump_reader.md
PANEL_DUMP_READER -- requirements
Module: panel_dump_reader

Interface
REQ-001 SHALL have parameter SETUP_CYCLES, default 10: cycles sw is held stable before any button press and after its release.
REQ-002 SHALL have parameter PULSE_CYCLES, default 10: cycles each button is held asserted.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 10: cycles after examine release before led is sampled.
REQ-004 clock  input  1  single clock; all state changes on its rising edge.
REQ-005 resetN  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
REQ-007 start_addr  input  12  first PDP-8 address to read; captured when start is accepted.
REQ-008 count  input  13  number of words to read, 0..4096; captured when start is accepted.
REQ-009 sw  output  12  front-panel switch value.
REQ-010 load_pc_btn  output  1  front-panel Load PC button.
REQ-011 examine_btn  output  1  front-panel Examine button; the panel shows mem[PC] on led and increments PC.
REQ-012 led  input  12  front-panel data display.
REQ-013 out_valid  output  1  out_address/out_data hold a valid word.
REQ-014 out_ready  input  1  consumer accepts the word.
REQ-015 out_address, out_data  output  12 each  address and value of the word being read.
REQ-016 out_last  output  1  set while out_valid is high, on the final word only.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle pulse when a dump completes.

Function
REQ-019 SHALL be an FSM with states IDLE, LPC_SETUP, LPC_PULSE, LPC_HOLD, EX_PULSE, EX_SETTLE, OUTPUT, FINISH.
REQ-020 IDLE with start=1 and count!=0: capture addr<=start_addr and remain<=count, drive sw=start_addr, go to LPC_SETUP.
REQ-021 IDLE with start=1 and count=0: go to FINISH; no button activity.
REQ-022 LPC_SETUP SHALL last SETUP_CYCLES cycles, then go to LPC_PULSE.
REQ-023 LPC_PULSE SHALL assert load_pc_btn for exactly PULSE_CYCLES cycles, then go to LPC_HOLD.
REQ-024 LPC_HOLD SHALL last SETUP_CYCLES cycles with both buttons low, then go to EX_PULSE.
REQ-025 sw SHALL stay constant from the cycle start is accepted until LPC_HOLD exits.
REQ-026 EX_PULSE SHALL assert examine_btn for exactly PULSE_CYCLES cycles, then go to EX_SETTLE.
REQ-027 EX_SETTLE SHALL last SETTLE_CYCLES cycles; on its last cycle register out_data<=led and out_address<=addr, then go to OUTPUT.
REQ-028 OUTPUT SHALL hold out_valid=1 with stable out_address/out_data/out_last until the cycle in which out_ready=1.
REQ-029 On the OUTPUT handshake cycle: addr<=addr+1 modulo 4096 (7777 octal wraps to 0000), remain<=remain-1.
REQ-030 After the handshake: go to FINISH if remain was 1, else go to EX_PULSE. Load PC is issued only once per dump.
REQ-031 out_last SHALL equal (remain==1) during OUTPUT.
REQ-032 FINISH SHALL assert done for one cycle, then return to IDLE.
REQ-033 start while not IDLE SHALL be ignored; it has no effect on the current dump.
REQ-034 load_pc_btn and examine_btn SHALL never be high in the same cycle.
REQ-035 out_ready while out_valid=0 SHALL be ignored.
REQ-036 Per-word latency, EX_PULSE entry to out_valid rising, SHALL be PULSE_CYCLES+SETTLE_CYCLES cycles.

Reset
REQ-037 resetN=0 SHALL immediately, without waiting for a clock edge, force: state=IDLE; sw=0; load_pc_btn=0; examine_btn=0; out_valid=0; out_address=0; out_data=0; out_last=0; busy=0; done=0; all counters=0.
REQ-038 Reset asserted mid-dump SHALL abandon the dump; done is not pulsed and no partial word is presented after reset release.
REQ-039 After reset release the block SHALL accept a new start on the first clock edge.

Verification
REQ-040 Single word: start_addr=0200 octal, count=1, panel model returning 7402 octal, out_ready tied high -> one Load PC pulse with sw=0200; one examine pulse; one word with out_address=0200, out_data=7402, out_last=1; done pulse; busy low after.
REQ-041 Wrap: start_addr=7776 octal, count=3 -> out_address sequence 7776, 7777, 0000; out_last only on 0000.
REQ-042 Backpressure: count=2, out_ready held low 50 cycles -> out_valid and data stay stable for those 50 cycles; the second examine_btn does not rise before the handshake.
REQ-043 count=0 -> done within 2 cycles of start; load_pc_btn and examine_btn never assert.
REQ-044 Reset during EX_PULSE of word 2 of 4 -> examine_btn and busy drop asynchronously; no done pulse; a new start after release dumps correctly.
REQ-045 start pulsed again mid-dump with a different start_addr -> ignored; the original address sequence completes unchanged.
